// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller and CPU bus arbiter.
// Passes CPU cycles to the system bus while idle. A CPU write to $4014 halts
// the CPU, copies page $XX00-$XXFF to the PPU OAM data port $2004, and then
// returns the bus to the CPU.
module oam_dma_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wen,
    input  logic        cpu_ren,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_wen,
    output logic        bus_ren,
    input  logic [7:0]  bus_din,
    output logic        dma_busy
);

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_ADDR  = 16'h2004;
    localparam logic [7:0]  LAST_IDX  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state;
    logic        phase;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic        trig;

    // A CPU write to the trigger register; only acted on in IDLE and HALT.
    assign trig = cpu_wen && (cpu_addr == TRIG_ADDR);

    // Read data always comes straight from the system bus.
    assign cpu_din = bus_din;

    // Sequencer: state, cycle phase, source pointer, byte buffer and the
    // registered cpu_rdy/dma_busy flags, which track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= 1'b0;
            page     <= 8'h00;
            idx      <= 8'h00;
            data     <= 8'h00;
            cpu_rdy  <= 1'b1;
            dma_busy <= 1'b0;
        end else begin
            phase <= ~phase;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        page     <= cpu_dout;
                        idx      <= 8'h00;
                        state    <= S_HALT;
                        cpu_rdy  <= 1'b0;
                        dma_busy <= 1'b1;
                    end
                end
                S_HALT: begin
                    // The 6502 ignores RDY on writes, so keep waiting until
                    // it sits on a read; a further $4014 write wins.
                    if (cpu_wen) begin
                        if (trig) begin
                            page <= cpu_dout;
                        end
                    end else if (phase) begin
                        state <= S_READ;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    // Burns one cycle so every READ lands on phase 0.
                    state <= S_READ;
                end
                S_READ: begin
                    data  <= bus_din;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    idx <= idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        state    <= S_IDLE;
                        cpu_rdy  <= 1'b1;
                        dma_busy <= 1'b0;
                    end else begin
                        state <= S_READ;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cpu_rdy  <= 1'b1;
                    dma_busy <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux decoded from the registered state: CPU pass-through in IDLE and
    // HALT, quiet bus in ALIGN, DMA-owned cycles in READ and WRITE.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_wen  = cpu_wen;
        bus_ren  = cpu_ren;
        case (state)
            S_ALIGN: begin
                bus_wen = 1'b0;
                bus_ren = 1'b0;
            end
            S_READ: begin
                bus_addr = {page, idx};
                bus_dout = data;
                bus_wen  = 1'b0;
                bus_ren  = 1'b1;
            end
            S_WRITE: begin
                bus_addr = OAM_ADDR;
                bus_dout = data;
                bus_wen  = 1'b1;
                bus_ren  = 1'b0;
            end
            default: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_wen  = cpu_wen;
                bus_ren  = cpu_ren;
            end
        endcase
    end

endmodule
